// File: rtl/alu_issue_arb.sv
// Two-requester issue arbiter in front of a shared combinational integer datapath (E issue stage, R response stage).
// Optional build macro ALU_ARB_STATS_EN adds saturating stat_conflict/stat_stall counters.
module alu_issue_arb #(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned FIX_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      dp_addsub_op1,
  output logic [31:0]      dp_addsub_op2,
  output logic [31:0]      dp_logic_op1,
  output logic [31:0]      dp_logic_op2,
  output logic [31:0]      dp_shift_op1,
  output logic [31:0]      dp_shift_op2,
  output logic             dp_req_add,
  output logic             dp_req_sub,
  output logic             dp_req_sll,
  output logic             dp_req_srl,
  output logic             dp_req_sra,
  output logic             dp_req_xor,
  output logic             dp_req_or,
  output logic             dp_req_and,
  input  logic [31:0]      dp_res_addsub,
  input  logic [31:0]      dp_res_logic,
  input  logic [31:0]      dp_res_shift,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      stat_conflict,
  output logic [15:0]      stat_stall
`endif
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLL = 4'd2,
    OP_SRL = 4'd3,
    OP_SRA = 4'd4,
    OP_XOR = 4'd5,
    OP_OR  = 4'd6,
    OP_AND = 4'd7
  } alu_op_e;

  logic             e_valid;
  logic             e_src;
  logic [3:0]       e_op;
  logic [31:0]      e_a;
  logic [31:0]      e_b;
  logic [TAG_W-1:0] e_tag;

  logic        prio;
  logic        grant0;
  logic        grant1;
  logic        r_load;
  logic        e_free;
  logic        use_addsub;
  logic        use_shift;
  logic        use_logic;
  logic [31:0] unit_res;

  assign r_load = e_valid & (~rsp_valid | rsp_ready);
  assign e_free = ~e_valid | r_load;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (e_free) begin
      if (req0_valid && (!req1_valid || !prio)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // prio names the requester that wins the next conflict: the one not granted last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (FIX_PRIO == 0 && (grant0 || grant1)) begin
      prio <= grant0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_src   <= 1'b0;
      e_op    <= '0;
      e_a     <= '0;
      e_b     <= '0;
      e_tag   <= '0;
    end else if (grant0 || grant1) begin
      e_valid <= 1'b1;
      e_src   <= grant1;
      e_op    <= grant1 ? req1_op  : req0_op;
      e_a     <= grant1 ? req1_a   : req0_a;
      e_b     <= grant1 ? req1_b   : req0_b;
      e_tag   <= grant1 ? req1_tag : req0_tag;
    end else if (r_load) begin
      e_valid <= 1'b0;
    end
  end

  always_comb begin
    use_addsub = 1'b0;
    use_shift  = 1'b0;
    use_logic  = 1'b0;
    dp_req_add = 1'b0;
    dp_req_sub = 1'b0;
    dp_req_sll = 1'b0;
    dp_req_srl = 1'b0;
    dp_req_sra = 1'b0;
    dp_req_xor = 1'b0;
    dp_req_or  = 1'b0;
    dp_req_and = 1'b0;
    if (e_valid) begin
      case (alu_op_e'(e_op))
        OP_ADD:  begin use_addsub = 1'b1; dp_req_add = 1'b1; end
        OP_SUB:  begin use_addsub = 1'b1; dp_req_sub = 1'b1; end
        OP_SLL:  begin use_shift  = 1'b1; dp_req_sll = 1'b1; end
        OP_SRL:  begin use_shift  = 1'b1; dp_req_srl = 1'b1; end
        OP_SRA:  begin use_shift  = 1'b1; dp_req_sra = 1'b1; end
        OP_XOR:  begin use_logic  = 1'b1; dp_req_xor = 1'b1; end
        OP_OR:   begin use_logic  = 1'b1; dp_req_or  = 1'b1; end
        OP_AND:  begin use_logic  = 1'b1; dp_req_and = 1'b1; end
        default: ;
      endcase
    end
  end

  // idle units see zero operands so they do not toggle on unrelated ops
  assign dp_addsub_op1 = use_addsub ? e_a : '0;
  assign dp_addsub_op2 = use_addsub ? e_b : '0;
  assign dp_logic_op1  = use_logic  ? e_a : '0;
  assign dp_logic_op2  = use_logic  ? e_b : '0;
  assign dp_shift_op1  = use_shift  ? e_a : '0;
  assign dp_shift_op2  = use_shift  ? {27'b0, e_b[4:0]} : '0;

  always_comb begin
    unit_res = '0;
    if (use_addsub)     unit_res = dp_res_addsub;
    else if (use_shift) unit_res = dp_res_shift;
    else if (use_logic) unit_res = dp_res_logic;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= 1'b0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (r_load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= unit_res;
      rsp_src   <= e_src;
      rsp_tag   <= e_tag;
      rsp_err   <= e_op[3];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict <= '0;
      stat_stall    <= '0;
    end else begin
      if (req0_valid && req1_valid && stat_conflict != '1) stat_conflict <= stat_conflict + 16'd1;
      if (rsp_valid && !rsp_ready && stat_stall != '1)     stat_stall    <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: cycle-level pipeline-occupancy model with golden arithmetic, plus literal checks.
// Also covers a FIX_PRIO=1 instance and the ALU_ARB_STATS_EN counters when that macro is defined.
module tb_alu_issue_arb;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          rsp_ready = 1'b1;
  logic          req0_ready, req1_ready, rsp_valid, rsp_src, rsp_err;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [31:0]   dp_addsub_op1, dp_addsub_op2, dp_logic_op1, dp_logic_op2, dp_shift_op1, dp_shift_op2;
  logic          dp_req_add, dp_req_sub, dp_req_sll, dp_req_srl, dp_req_sra, dp_req_xor, dp_req_or, dp_req_and;
  logic [31:0]   dp_res_addsub, dp_res_logic, dp_res_shift;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   stat_conflict, stat_stall, f_stat_conflict, f_stat_stall;
`endif

  // FIX_PRIO=1 instance: same requests, consumer always ready
  logic          f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_src, f_rsp_err;
  logic [31:0]   f_rsp_data;
  logic [TW-1:0] f_rsp_tag;
  logic [31:0]   f_op1a, f_op2a, f_op1l, f_op2l, f_op1s, f_op2s;
  logic [7:0]    f_req;

  alu_issue_arb #(.TAG_W(TW), .FIX_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a),
    .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a),
    .req1_b(req1_b), .req1_tag(req1_tag),
    .dp_addsub_op1(dp_addsub_op1), .dp_addsub_op2(dp_addsub_op2),
    .dp_logic_op1(dp_logic_op1), .dp_logic_op2(dp_logic_op2),
    .dp_shift_op1(dp_shift_op1), .dp_shift_op2(dp_shift_op2),
    .dp_req_add(dp_req_add), .dp_req_sub(dp_req_sub), .dp_req_sll(dp_req_sll), .dp_req_srl(dp_req_srl),
    .dp_req_sra(dp_req_sra), .dp_req_xor(dp_req_xor), .dp_req_or(dp_req_or), .dp_req_and(dp_req_and),
    .dp_res_addsub(dp_res_addsub), .dp_res_logic(dp_res_logic), .dp_res_shift(dp_res_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
    , .stat_conflict(stat_conflict), .stat_stall(stat_stall)
`endif
  );

  alu_issue_arb #(.TAG_W(TW), .FIX_PRIO(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a),
    .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a),
    .req1_b(req1_b), .req1_tag(req1_tag),
    .dp_addsub_op1(f_op1a), .dp_addsub_op2(f_op2a), .dp_logic_op1(f_op1l), .dp_logic_op2(f_op2l),
    .dp_shift_op1(f_op1s), .dp_shift_op2(f_op2s),
    .dp_req_add(f_req[0]), .dp_req_sub(f_req[1]), .dp_req_sll(f_req[2]), .dp_req_srl(f_req[3]),
    .dp_req_sra(f_req[4]), .dp_req_xor(f_req[5]), .dp_req_or(f_req[6]), .dp_req_and(f_req[7]),
    .dp_res_addsub(32'h0), .dp_res_logic(32'h0), .dp_res_shift(32'h0),
    .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_data(f_rsp_data), .rsp_src(f_rsp_src),
    .rsp_tag(f_rsp_tag), .rsp_err(f_rsp_err)
`ifdef ALU_ARB_STATS_EN
    , .stat_conflict(f_stat_conflict), .stat_stall(f_stat_stall)
`endif
  );

  // shared combinational datapath, driven only by the DUT's op lines
  always_comb begin
    dp_res_addsub = dp_req_sub ? dp_addsub_op1 - dp_addsub_op2 : dp_addsub_op1 + dp_addsub_op2;
    if (dp_req_sll)      dp_res_shift = dp_shift_op1 << dp_shift_op2[4:0];
    else if (dp_req_sra) dp_res_shift = 32'($signed(dp_shift_op1) >>> dp_shift_op2[4:0]);
    else                 dp_res_shift = dp_shift_op1 >> dp_shift_op2[4:0];
    if (dp_req_xor)      dp_res_logic = dp_logic_op1 ^ dp_logic_op2;
    else if (dp_req_or)  dp_res_logic = dp_logic_op1 | dp_logic_op2;
    else                 dp_res_logic = dp_logic_op1 & dp_logic_op2;
  end

  function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return a >> b[4:0];
      4'd4: return 32'($signed(a) >>> b[4:0]);
      4'd5: return a ^ b;
      4'd6: return a | b;
      4'd7: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct packed {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [TW-1:0] tag;} req_t;
  typedef struct packed {logic v; logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [TW-1:0] tag; logic src;} slot_t;
  typedef struct packed {logic [31:0] data; logic src; logic [TW-1:0] tag; logic err; logic [31:0] cyc;} rsp_t;

  req_t  q0[$], q1[$];
  rsp_t  rsp_log[$];
  slot_t m_e = '0, m_r = '0;
  logic  m_prio = 1'b0;
  logic [15:0] m_conf = '0, m_stall = '0;
  logic  acc0 = 1'b0, acc1 = 1'b0;
  logic [31:0] cyc = '0, acc_cyc0 = '0;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one free issue slot exists when E is empty or E drains into R this cycle
  function automatic void exp_grant(output logic g0, output logic g1);
    logic room;
    room = !m_e.v || !m_r.v || rsp_ready;
    g0 = room && req0_valid && (!req1_valid || !m_prio);
    g1 = room && req1_valid && !g0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = '0; m_r = '0; m_prio = 1'b0; m_conf = '0; m_stall = '0;
    end else begin
      logic g0, g1, adv;
      exp_grant(g0, g1);
      if (req0_valid && req1_valid && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
      if (m_r.v && !rsp_ready && m_stall != 16'hFFFF)     m_stall = m_stall + 16'd1;
      adv = m_e.v && (!m_r.v || rsp_ready);
      if (adv)            m_r = m_e;
      else if (rsp_ready) m_r.v = 1'b0;
      if (g0)       begin m_e = {1'b1, req0_op, req0_a, req0_b, req0_tag, 1'b0}; m_prio = 1'b1; end
      else if (g1)  begin m_e = {1'b1, req1_op, req1_a, req1_b, req1_tag, 1'b1}; m_prio = 1'b0; end
      else if (adv) m_e.v = 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) {req0_op, req0_a, req0_b, req0_tag} = q0[0];
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) {req1_op, req1_a, req1_b, req1_tag} = q1[0];
  end

  always @(negedge clk) begin
    acc0 = rst_n && req0_valid && req0_ready;
    acc1 = rst_n && req1_valid && req1_ready;
    if (acc0) acc_cyc0 = cyc;
    if (rst_n) begin
      logic g0, g1;
      logic [7:0] ereq;
      logic [1:0] unit;
      logic [31:0] ed;
      exp_grant(g0, g1);
      chk("ready", 192'({req0_ready, req1_ready}), 192'({g0, g1}));
      chk("rsp_valid", 192'(rsp_valid), 192'(m_r.v));
      if (m_r.v) begin
        ed = m_r.op[3] ? 32'h0 : golden(m_r.op, m_r.a, m_r.b);
        chk("rsp_fields", 192'({rsp_data, rsp_src, rsp_tag, rsp_err}), 192'({ed, m_r.src, m_r.tag, m_r.op[3]}));
      end
      ereq = (m_e.v && !m_e.op[3]) ? (8'd1 << m_e.op[2:0]) : 8'd0;
      chk("dp_req", 192'({dp_req_and, dp_req_or, dp_req_xor, dp_req_sra, dp_req_srl, dp_req_sll, dp_req_sub, dp_req_add}),
          192'(ereq));
      unit = !m_e.v ? 2'd0 : (m_e.op <= 4'd1) ? 2'd1 : (m_e.op <= 4'd4) ? 2'd2 : (m_e.op <= 4'd7) ? 2'd3 : 2'd0;
      chk("dp_operands",
          {dp_addsub_op1, dp_addsub_op2, dp_logic_op1, dp_logic_op2, dp_shift_op1, dp_shift_op2},
          {(unit == 2'd1) ? m_e.a : 32'h0, (unit == 2'd1) ? m_e.b : 32'h0,
           (unit == 2'd3) ? m_e.a : 32'h0, (unit == 2'd3) ? m_e.b : 32'h0,
           (unit == 2'd2) ? m_e.a : 32'h0, (unit == 2'd2) ? {27'b0, m_e.b[4:0]} : 32'h0});
      chk("fix_prio_ready", 192'({f_req0_ready, f_req1_ready}), 192'({req0_valid, req1_valid && !req0_valid}));
`ifdef ALU_ARB_STATS_EN
      chk("stat_conflict", 192'(stat_conflict), 192'(m_conf));
      chk("stat_stall", 192'(stat_stall), 192'(m_stall));
`endif
      if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_data, rsp_src, rsp_tag, rsp_err, cyc});
    end
  end

  task automatic push0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    q0.push_back({op, a, b, t});
  endtask
  task automatic push1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    q1.push_back({op, a, b, t});
  endtask

  task automatic drain(input string nm);
    int unsigned n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_e.v || m_r.v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s_drain: got timeout after %0d cycles, expected pipeline empty", nm, n);
    end
  endtask

  task automatic lit(input string nm, input int unsigned idx, input logic [31:0] d, input logic s,
                     input logic [TW-1:0] t, input logic e);
    n_tests++;
    if (idx >= rsp_log.size()) begin
      n_fail++;
      $display("FAIL %s: got no response #%0d, expected data 0x%0h tag %0d", nm, idx, d, t);
    end else if ({rsp_log[idx].data, rsp_log[idx].src, rsp_log[idx].tag, rsp_log[idx].err} !== {d, s, t, e}) begin
      n_fail++;
      $display("FAIL %s: got data 0x%0h src %0d tag %0d err %0d, expected data 0x%0h src %0d tag %0d err %0d",
               nm, rsp_log[idx].data, rsp_log[idx].src, rsp_log[idx].tag, rsp_log[idx].err, d, s, t, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, lat, n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 192'(rsp_valid), 192'(0));
    chk("reset_rsp_regs", 192'({rsp_data, rsp_src, rsp_tag, rsp_err}), 192'(0));
    chk("reset_dp_req", 192'({dp_req_and, dp_req_or, dp_req_xor, dp_req_sra, dp_req_srl, dp_req_sll, dp_req_sub, dp_req_add}),
        192'(0));
    #1 rst_n = 1'b1;

    // single ADD with wraparound, plus latency
    @(posedge clk); #2;
    base = rsp_log.size();
    push0(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    drain("single");
    lit("single_add", base, 32'h0, 1'b0, 4'd3, 1'b0);
    lat = (rsp_log.size() > base) ? rsp_log[base].cyc - acc_cyc0 : 999;
    chk("single_latency", 192'(lat), 192'(2));

    // op coverage; the trailing req1 op leaves prio on requester 0
    @(posedge clk); #2;
    base = rsp_log.size();
    push0(4'd1, 32'd5, 32'd7, 4'd1);
    push0(4'd4, 32'h8000_0000, 32'h24, 4'd2);
    push0(4'd3, 32'h8000_0000, 32'h24, 4'd3);
    push0(4'd7, 32'hF0F0, 32'h0FF0, 4'd4);
    drain("ops0");
    @(posedge clk); #2;
    push1(4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd5);
    drain("ops1");
    lit("op_sub", base, 32'hFFFF_FFFE, 1'b0, 4'd1, 1'b0);
    lit("op_sra", base + 1, 32'hF800_0000, 1'b0, 4'd2, 1'b0);
    lit("op_srl", base + 2, 32'h0800_0000, 1'b0, 4'd3, 1'b0);
    lit("op_and", base + 3, 32'h0000_00F0, 1'b0, 4'd4, 1'b0);
    lit("op_xor", base + 4, 32'hF0F0_F0F0, 1'b1, 4'd5, 1'b0);

    // conflict: round-robin alternation starting with requester 0
    @(posedge clk); #2;
    base = rsp_log.size();
    for (int i = 0; i < 4; i++) begin
      push0(4'd0, 32'(i + 1), 32'(i + 1), 4'(i));
      push1(4'd6, 32'h10, 32'h01, 4'(8 + i));
    end
    drain("conflict");
    lit("rr_0", base, 32'd2, 1'b0, 4'd0, 1'b0);
    lit("rr_1", base + 1, 32'h11, 1'b1, 4'd8, 1'b0);
    lit("rr_2", base + 2, 32'd4, 1'b0, 4'd1, 1'b0);
    lit("rr_3", base + 3, 32'h11, 1'b1, 4'd9, 1'b0);

    // backpressure: three ops queued behind a stalled consumer
    @(posedge clk); #1 rsp_ready = 1'b0; #1;
    base = rsp_log.size();
    push0(4'd0, 32'd10, 32'd1, 4'd4);
    push0(4'd0, 32'd20, 32'd2, 4'd5);
    push0(4'd0, 32'd30, 32'd3, 4'd6);
    repeat (5) @(negedge clk);
    chk("bp_req0_ready", 192'(req0_ready), 192'(0));
    chk("bp_rsp_hold", 192'({rsp_valid, rsp_data, rsp_tag}), 192'({1'b1, 32'd11, 4'd4}));
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("bp");
    chk("bp_count", 192'(rsp_log.size() - base), 192'(3));
    lit("bp_0", base, 32'd11, 1'b0, 4'd4, 1'b0);
    lit("bp_1", base + 1, 32'd22, 1'b0, 4'd5, 1'b0);
    lit("bp_2", base + 2, 32'd33, 1'b0, 4'd6, 1'b0);

    // illegal opcode
    @(posedge clk); #2;
    base = rsp_log.size();
    push0(4'hC, 32'h123, 32'h456, 4'd9);
    drain("illegal");
    lit("illegal", base, 32'h0, 1'b0, 4'd9, 1'b1);

    // reset while R and E both hold ops
    @(posedge clk); #2;
    push0(4'd0, 32'd1, 32'd1, 4'd1);
    push0(4'd0, 32'd2, 32'd2, 4'd2);
    push0(4'd0, 32'd3, 32'd3, 4'd3);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_busy", 192'(rsp_valid), 192'(1));
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("midreset_rsp_valid", 192'(rsp_valid), 192'(0));
    chk("midreset_dp_req", 192'({dp_req_and, dp_req_or, dp_req_xor, dp_req_sra, dp_req_srl, dp_req_sll, dp_req_sub, dp_req_add}),
        192'(0));
    base = rsp_log.size();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    push0(4'd1, 32'd9, 32'd4, 4'd7);
    drain("post_reset");
    chk("post_reset_count", 192'(rsp_log.size() - base), 192'(1));
    lit("post_reset", base, 32'd5, 1'b0, 4'd7, 1'b0);

    // three conflict cycles, then two stall cycles
    @(posedge clk); #2;
    push0(4'd0, 32'd1, 32'd2, 4'd0);
    push0(4'd0, 32'd3, 32'd4, 4'd1);
    push1(4'd0, 32'd5, 32'd6, 4'd2);
    push1(4'd0, 32'd7, 32'd8, 4'd3);
    drain("stats_conflict");
    @(posedge clk); #1 rsp_ready = 1'b0; #1;
    push0(4'd0, 32'd100, 32'd1, 4'd5);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", 192'(rsp_valid), 192'(1));
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain("stats_stall");
`ifdef ALU_ARB_STATS_EN
    chk("stat_conflict_final", 192'(stat_conflict), 192'(3));
    chk("stat_stall_final", 192'(stat_stall), 192'(2));
`endif

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
